// File: rtl/blink_driver.sv
// Turns single-cycle event strobes into fixed ON/GAP indicator blinks, one per event,
// queueing events that arrive mid-blink so they replay back-to-back.
module blink_driver #(
  parameter int CLK_FREQUENCY = 40_000_000,
  parameter int BLINK_HZ      = 2,
  parameter int PEND_W        = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trigger,
  input  logic              clear,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int PERIOD     = CLK_FREQUENCY / BLINK_HZ;
  localparam int ON_CYCLES  = PERIOD / 2;
  localparam int GAP_CYCLES = PERIOD - ON_CYCLES;
  localparam int CNT_W      = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              led_nxt;
  logic [PEND_W-1:0] pending_nxt;
  logic              overflow_nxt;
  logic              inc, dec;

  // Saturating queue update: an increment at the ceiling is reported, not wrapped.
  function automatic logic [PEND_W:0] pend_update(input logic [PEND_W-1:0] cur,
                                                  input logic up, input logic down);
    logic [PEND_W-1:0] nxt;
    logic              drop;
    nxt  = cur;
    drop = 1'b0;
    if (up && !down) begin
      if (cur == PEND_MAX) drop = 1'b1;
      else                 nxt  = cur + PEND_W'(1);
    end else if (down && !up) begin
      nxt = cur - PEND_W'(1);
    end
    return {drop, nxt};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      led      <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      led      <= led_nxt;
      pending  <= pending_nxt;
      overflow <= overflow_nxt;
    end
  end

  always_comb begin
    logic [PEND_W:0] upd;
    state_nxt    = state;
    cnt_nxt      = cnt;
    led_nxt      = led;
    inc          = 1'b0;
    dec          = 1'b0;
    pending_nxt  = pending;
    overflow_nxt = overflow;
    upd          = '0;

    case (state)
      IDLE: begin
        if (trigger) begin
          state_nxt = ON;
          cnt_nxt   = '0;
          led_nxt   = 1'b1;
        end
      end
      ON: begin
        inc = trigger;
        if (cnt == ON_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
          led_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        inc = trigger;
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          if (pending != '0) begin
            dec       = 1'b1;
            state_nxt = ON;
            led_nxt   = 1'b1;
          end else if (trigger) begin
            // Empty queue: the strobe launches the next blink itself.
            inc       = 1'b0;
            state_nxt = ON;
            led_nxt   = 1'b1;
          end else begin
            state_nxt = IDLE;
            led_nxt   = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        led_nxt   = 1'b0;
      end
    endcase

    upd         = pend_update(pending, inc, dec);
    pending_nxt = upd[PEND_W-1:0];
    if (upd[PEND_W]) overflow_nxt = 1'b1;

    if (clear) begin
      state_nxt    = IDLE;
      cnt_nxt      = '0;
      led_nxt      = 1'b0;
      pending_nxt  = '0;
      overflow_nxt = 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_blink_driver.sv
// Directed bench for blink_driver with PERIOD 10 (ON 5, GAP 5) and a 3-bit queue.
module tb_blink_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       trigger;
  logic       clear;
  logic       led;
  logic       busy;
  logic [2:0] pending;
  logic       overflow;

  int tests  = 0;
  int failed = 0;
  int rises  = 0;
  logic prev_led = 1'b0;

  typedef struct {
    logic       trig;
    logic       clr;
    logic       led;
    logic       busy;
    logic [2:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  blink_driver #(.CLK_FREQUENCY(20), .BLINK_HZ(2), .PEND_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .clear(clear),
    .led(led), .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic t, input logic c);
    trigger = t;
    clear   = c;
    @(posedge clk);
    #1;
    if (led && !prev_led) rises++;
    prev_led = led;
  endtask

  task automatic drain(input string name, input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check({name, " drained"}, int'(busy), 0);
  endtask

  function automatic void add(input logic t, input logic c, input logic l, input logic b,
                              input logic [2:0] p, input logic o);
    vec_t v;
    v.trig = t; v.clr = c; v.led = l; v.busy = b; v.pend = p; v.ovf = o;
    vecs.push_back(v);
  endfunction

  initial begin
    // Single blink from IDLE, then a trigger on the last GAP cycle with an empty queue.
    add(1, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 4; i++) add(0, 0, 1, 1, 0, 0);
    for (int i = 5; i <= 9; i++) add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 4; i++) add(0, 0, 1, 1, 0, 0);
    for (int i = 5; i <= 9; i++) add(0, 0, 0, 1, 0, 0);
    add(1, 0, 1, 1, 0, 0);
    for (int i = 11; i <= 14; i++) add(0, 0, 1, 1, 0, 0);
    for (int i = 15; i <= 19; i++) add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0);

    trigger = 1'b0;
    clear   = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("reset led", int'(led), 0);
    check("reset busy", int'(busy), 0);
    check("reset pending", int'(pending), 0);
    check("reset overflow", int'(overflow), 0);
    #10 reset_n = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].trig, vecs[i].clr);
      check($sformatf("vec%0d led", i), int'(led), int'(vecs[i].led));
      check($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].busy));
      check($sformatf("vec%0d pending", i), int'(pending), int'(vecs[i].pend));
      check($sformatf("vec%0d overflow", i), int'(overflow), int'(vecs[i].ovf));
    end

    // Three queued events: four back-to-back blinks.
    for (int i = 0; i <= 40; i++) begin
      cycle(i <= 3, 1'b0);
      if (i == 3)  check("q3 pending after burst", int'(pending), 3);
      if (i == 9)  check("q3 gap before replay", int'(led), 0);
      if (i == 10) check("q3 pending blink2", int'(pending), 2);
      if (i == 10) check("q3 led blink2", int'(led), 1);
      if (i == 20) check("q3 pending blink3", int'(pending), 1);
      if (i == 30) check("q3 pending blink4", int'(pending), 0);
      if (i == 30) check("q3 led blink4", int'(led), 1);
      if (i == 39) check("q3 busy at 39", int'(busy), 1);
      if (i == 40) check("q3 busy at 40", int'(busy), 0);
    end

    // Trigger on last GAP cycle with two queued events: queue depth unchanged.
    for (int i = 0; i <= 10; i++) begin
      cycle((i <= 2) || (i == 10), 1'b0);
      if (i == 2) check("lastgap pending setup", int'(pending), 2);
      if (i == 9) check("lastgap led before", int'(led), 0);
      if (i == 10) check("lastgap pending", int'(pending), 2);
      if (i == 10) check("lastgap led", int'(led), 1);
    end
    drain("lastgap", 60);

    // Nine consecutive events: one direct, seven queued, one dropped.
    rises = 0;
    prev_led = led;
    for (int i = 0; i <= 8; i++) cycle(1'b1, 1'b0);
    check("sat pending", int'(pending), 7);
    check("sat overflow", int'(overflow), 1);
    drain("sat", 100);
    check("sat blink count", rises, 8);
    check("sat overflow sticky", int'(overflow), 1);
    check("sat pending empty", int'(pending), 0);

    // Asynchronous reset mid-ON with events queued and overflow set.
    for (int i = 0; i <= 2; i++) cycle(1'b1, 1'b0);
    check("areset setup pending", int'(pending), 2);
    check("areset setup overflow", int'(overflow), 1);
    #2 reset_n = 1'b0;
    #1;
    check("areset led", int'(led), 0);
    check("areset busy", int'(busy), 0);
    check("areset pending", int'(pending), 0);
    check("areset overflow", int'(overflow), 0);
    #2 reset_n = 1'b1;
    prev_led = led;

    // Clear in the third ON cycle with four queued and overflow set.
    for (int i = 0; i <= 32; i++) cycle(i <= 8, 1'b0);
    check("clr setup pending", int'(pending), 4);
    check("clr setup overflow", int'(overflow), 1);
    check("clr setup led", int'(led), 1);
    cycle(1'b1, 1'b1);
    check("clr busy", int'(busy), 0);
    check("clr led", int'(led), 0);
    check("clr pending", int'(pending), 0);
    check("clr overflow", int'(overflow), 0);
    cycle(1'b0, 1'b0);
    check("clr trigger discarded", int'(busy), 0);
    cycle(1'b1, 1'b0);
    check("post-clr led 1", int'(led), 1);
    for (int j = 2; j <= 5; j++) begin
      cycle(1'b0, 1'b0);
      check($sformatf("post-clr led %0d", j), int'(led), 1);
    end
    cycle(1'b0, 1'b0);
    check("post-clr gap led", int'(led), 0);
    check("post-clr gap busy", int'(busy), 1);
    drain("post-clr", 20);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
